pipeline_sequencer: RTL and testbench

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Four-stage command sequencer (FETCH/DECODE/EXECUTE/STORE) fed by a small FIFO.
// One command is in flight at a time; STORE hands off directly to the next queued command.
module pipeline_sequencer #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    input  logic [ID_W-1:0]        cmd_id,
    output logic                   cmd_ready,
    input  logic                   stall,
    input  logic                   exec_done,
    input  logic                   flush,
    output logic [3:0]             stage,
    output logic [ID_W-1:0]        cur_id,
    output logic                   busy,
    output logic                   retire_valid,
    output logic [ID_W-1:0]        retire_id,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            retired_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_STORE   = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ID_W-1:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [ID_W-1:0]   cur_id_r;
    logic              retire_valid_r;
    logic [ID_W-1:0]   retire_id_r;
    logic [15:0]       retired_cnt_r;
    logic              push_s;
    logic              pop_s;
    logic              retire_s;

    // Ready is forced low while reset is held, independent of the clock.
    assign cmd_ready = rst_n & (count_r < DEPTH_C) & ~flush;
    assign push_s    = cmd_valid & cmd_ready;

    // Next-state, pop and retire decisions; flush outranks stall, which outranks progress.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        retire_s    = 1'b0;
        if (flush) begin
            state_nxt_s = ST_IDLE;
        end else if (stall) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (count_r != CNT_ZERO) begin
                        pop_s       = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_FETCH:  state_nxt_s = ST_DECODE;
                ST_DECODE: state_nxt_s = ST_EXECUTE;
                ST_EXECUTE: begin
                    if (exec_done) begin
                        state_nxt_s = ST_STORE;
                    end else begin
                        state_nxt_s = ST_EXECUTE;
                    end
                end
                ST_STORE: begin
                    retire_s = 1'b1;
                    if (count_r != CNT_ZERO) begin
                        pop_s       = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Stage and busy decode straight from the state register.
    always_comb begin
        stage = 4'b0000;
        case (state_r)
            ST_FETCH:   stage = 4'b0001;
            ST_DECODE:  stage = 4'b0010;
            ST_EXECUTE: stage = 4'b0100;
            ST_STORE:   stage = 4'b1000;
            default:    stage = 4'b0000;
        endcase
    end

    assign busy         = (state_r != ST_IDLE);
    assign cur_id       = cur_id_r;
    assign retire_valid = retire_valid_r;
    assign retire_id    = retire_id_r;
    assign fifo_count   = count_r;
    assign retired_cnt  = retired_cnt_r;

    // FIFO storage; entries need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= cmd_id;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sequencer state, in-flight ID and retire bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            cur_id_r       <= {ID_W{1'b0}};
            retire_valid_r <= 1'b0;
            retire_id_r    <= {ID_W{1'b0}};
            retired_cnt_r  <= 16'h0000;
        end else begin
            state_r        <= state_nxt_s;
            retire_valid_r <= retire_s;
            if (pop_s) begin
                cur_id_r <= mem_r[rd_ptr_r];
            end
            if (retire_s) begin
                retire_id_r   <= cur_id_r;
                retired_cnt_r <= retired_cnt_r + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus random traffic,
// all compared against a queue-based behavioural model of the command flow.
module tb_pipeline_sequencer;

    localparam int DEPTH = 4;
    localparam int ID_W  = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic [ID_W-1:0] cmd_id = '0;
    logic            stall = 1'b0;
    logic            exec_done = 1'b0;
    logic            flush = 1'b0;
    logic            cmd_ready;
    logic [3:0]      stage;
    logic [ID_W-1:0] cur_id;
    logic            busy;
    logic            retire_valid;
    logic [ID_W-1:0] retire_id;
    logic [CW-1:0]   fifo_count;
    logic [15:0]     retired_cnt;

    pipeline_sequencer #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_id(cmd_id),
        .cmd_ready(cmd_ready), .stall(stall), .exec_done(exec_done), .flush(flush),
        .stage(stage), .cur_id(cur_id), .busy(busy), .retire_valid(retire_valid),
        .retire_id(retire_id), .fifo_count(fifo_count), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 fetch, 2 decode, 3 execute, 4 store.
    logic [ID_W-1:0] m_q[$];
    int              m_phase;
    logic [ID_W-1:0] m_cur;
    logic            m_rv;
    logic [ID_W-1:0] m_rid;
    logic [15:0]     m_cnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase = 0;
        m_cur   = '0;
        m_rv    = 1'b0;
        m_rid   = '0;
        m_cnt   = 16'h0000;
    endtask

    task automatic model_edge();
        bit ready;
        bit push;
        bit do_pop;
        ready  = (m_q.size() < DEPTH) && !flush;
        push   = cmd_valid && ready;
        do_pop = 1'b0;
        m_rv   = 1'b0;
        if (flush) begin
            m_phase = 0;
            m_q.delete();
        end else begin
            if (!stall) begin
                case (m_phase)
                    0: do_pop = (m_q.size() > 0);
                    1, 2: m_phase = m_phase + 1;
                    3: if (exec_done) m_phase = 4;
                    4: begin
                        m_rv    = 1'b1;
                        m_rid   = m_cur;
                        m_cnt   = m_cnt + 16'h0001;
                        m_phase = 0;
                        do_pop  = (m_q.size() > 0);
                    end
                    default: m_phase = 0;
                endcase
            end
            if (do_pop) begin
                m_cur   = m_q.pop_front();
                m_phase = 1;
            end
            if (push) m_q.push_back(cmd_id);
        end
    endtask

    task automatic check_all();
        logic [3:0] es;
        es = (m_phase == 0) ? 4'b0000 : 4'(4'b0001 << (m_phase - 1));
        chk("stage",        32'(stage),        32'(es));
        chk("busy",         32'(busy),         32'(m_phase != 0));
        chk("cur_id",       32'(cur_id),       32'(m_cur));
        chk("retire_valid", 32'(retire_valid), 32'(m_rv));
        chk("retire_id",    32'(retire_id),    32'(m_rid));
        chk("fifo_count",   32'(fifo_count),   32'(m_q.size()));
        chk("retired_cnt",  32'(retired_cnt),  32'(m_cnt));
        chk("cmd_ready",    32'(cmd_ready),    32'(rst_n && (m_q.size() < DEPTH) && !flush));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic set_in(input bit v, input logic [ID_W-1:0] id, input bit s, input bit e, input bit f);
        cmd_valid = v;
        cmd_id    = id;
        stall     = s;
        exec_done = e;
        flush     = f;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        bit got;
        int nst;
        logic [15:0] cnt_before;
        logic [ID_W-1:0] got_q[$];

        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Single command, exec_done held high
        set_in(1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
        cycle();
        set_in(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        lat = 1; got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            cycle();
            lat++;
            if (retire_valid) begin
                got = 1'b1;
                chk("single_lat", 32'(lat), 32'd6);
                chk("single_id", 32'(retire_id), 32'h5);
                chk("single_cnt", 32'(retired_cnt), 32'd1);
            end
        end
        if (!got) chk("single_timeout", 32'd0, 32'd1);
        cycle();
        chk("single_idle", 32'(busy), 32'd0);

        // Stall three cycles in DECODE
        set_in(1'b1, 4'h7, 1'b0, 1'b1, 1'b0);
        cycle();
        cmd_valid = 1'b0;
        lat = 1; got = 1'b0; nst = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            stall = (m_phase == 2) && (nst < 3);
            if (stall) nst++;
            cycle();
            lat++;
            if (retire_valid) begin
                got = 1'b1;
                chk("stall_lat", 32'(lat), 32'd9);
                chk("stall_id", 32'(retire_id), 32'h7);
            end
        end
        if (!got) chk("stall_timeout", 32'd0, 32'd1);
        stall = 1'b0;

        // Fill and order
        for (int id = 1; id <= 5; id++) begin
            set_in(1'b1, 4'(id), 1'b0, 1'b0, 1'b0);
            cycle();
        end
        chk("fill_ready", 32'(cmd_ready), 32'd0);
        chk("fill_count", 32'(fifo_count), 32'd4);
        set_in(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        got_q.delete();
        for (int i = 0; i < 40 && got_q.size() < 5; i++) begin
            cycle();
            if (retire_valid) got_q.push_back(retire_id);
            if (got_q.size() < 5) chk("fill_nogap", 32'(busy), 32'd1);
        end
        chk("fill_n", 32'(got_q.size()), 32'd5);
        for (int k = 0; k < got_q.size(); k++) chk("fill_order", 32'(got_q[k]), 32'(k + 1));
        cycle();

        // Flush in STORE with two queued
        set_in(1'b1, 4'hA, 1'b0, 1'b1, 1'b0); cycle();
        set_in(1'b1, 4'hB, 1'b0, 1'b1, 1'b0); cycle();
        set_in(1'b1, 4'hC, 1'b0, 1'b1, 1'b0); cycle();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10 && m_phase != 4; i++) cycle();
        chk("flush_in_store", 32'(stage), 32'h8);
        chk("flush_queued", 32'(fifo_count), 32'd2);
        cnt_before = m_cnt;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_stage", 32'(stage), 32'd0);
        chk("flush_count", 32'(fifo_count), 32'd0);
        chk("flush_noretire", 32'(retire_valid), 32'd0);
        chk("flush_cnt", 32'(retired_cnt), 32'(cnt_before));
        cycle();

        // Async reset in EXECUTE
        set_in(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        cycle();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10 && m_phase != 3; i++) cycle();
        chk("rst_in_exec", 32'(stage), 32'h4);
        rst_n = 1'b0;
        #1;
        chk("arst_stage", 32'(stage), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cur", 32'(cur_id), 32'd0);
        chk("arst_rv", 32'(retire_valid), 32'd0);
        chk("arst_rid", 32'(retire_id), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_cnt", 32'(retired_cnt), 32'd0);
        chk("arst_ready", 32'(cmd_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 4'hD, 1'b0, 1'b1, 1'b0);
        cycle();
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        chk("after_rst_cnt", 32'(retired_cnt), 32'd1);

        // Retired counter wrap
        force dut.retired_cnt_r = 16'hFFFF;
        #1;
        release dut.retired_cnt_r;
        m_cnt = 16'hFFFF;
        @(negedge clk);
        set_in(1'b1, 4'h3, 1'b0, 1'b1, 1'b0);
        cycle();
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        chk("wrap_cnt", 32'(retired_cnt), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 99) < 60, 4'($urandom), $urandom_range(0, 99) < 15,
                   $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
